write_reg: RTL and testbench

Writeback-side counterpart of the operand-read path. It steers each retiring writeback either to the local register file or, when the destination address is one of the four neighbour-mapped addresses (28–31), into a per-direction output queue. Each queue drives one neighbour PE with a valid/ready handshake. The block sits between the PE writeback stage and the mesh links. It raises a stall whenever a neighbour queue cannot accept a write.

---
 rtl/kira_pe_pkg.sv | 30 +++
 rtl/write_reg_nbr_fifo.sv | 55 +++++
 rtl/write_reg.sv | 82 ++++++++
 tb/tb_write_reg.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/kira_pe_pkg.sv
// Shared PE constants: neighbour-mapped register addresses, link directions and address decode helpers.
// Both the operand-read side and the writeback side decode links from these.
package kira_pe_pkg;

  localparam logic [4:0] ADDR_N = 5'd31;
  localparam logic [4:0] ADDR_S = 5'd30;
  localparam logic [4:0] ADDR_W = 5'd29;
  localparam logic [4:0] ADDR_E = 5'd28;

  typedef enum logic [1:0] {
    DIR_N = 2'd0,
    DIR_S = 2'd1,
    DIR_W = 2'd2,
    DIR_E = 2'd3
  } dir_e;

  function automatic logic is_nbr_addr(input logic [4:0] addr);
    return addr >= ADDR_E;
  endfunction

  function automatic dir_e addr_to_dir(input logic [4:0] addr);
    case (addr)
      ADDR_N:  return DIR_N;
      ADDR_S:  return DIR_S;
      ADDR_W:  return DIR_W;
      default: return DIR_E;
    endcase
  endfunction

endpackage

// File: rtl/write_reg_nbr_fifo.sv
// Per-direction neighbour queue; push visible on head/valid 1 cycle later, 1 entry/cycle throughput.
// full_or_popping reports that a push is accepted this cycle: not full, or full while the head is popped.
module nbr_fifo #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic [XLEN-1:0] push_data,
  output logic            full_or_popping,
  input  logic            pop,
  output logic [XLEN-1:0] head,
  output logic            valid
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [XLEN-1:0] mem [DEPTH];
  logic [PW-1:0]   rptr;
  logic [PW-1:0]   wptr;
  logic [CW-1:0]   count;
  logic            pop_fire;
  logic            push_fire;

  assign valid           = (count != '0);
  assign head            = mem[rptr];
  assign pop_fire        = pop & valid;
  assign full_or_popping = (count != FULL) || pop_fire;
  assign push_fire       = push & full_or_popping;

  // Storage is cleared on reset so the head reads as zero until the first push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_fire) begin
        mem[wptr] <= push_data;
        wptr      <= wptr + PW'(1);
      end
      if (pop_fire) rptr <= rptr + PW'(1);
      case ({push_fire, pop_fire})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/write_reg.sv
// Writeback steering: local RF write (combinational rf_we) or push into one of four neighbour queues.
// wb_stall is combinational and raised when the addressed queue cannot accept this cycle.
module write_reg
  import kira_pe_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            rf_we,
  output logic            wb_stall,
  output logic [XLEN-1:0] o_n,
  output logic [XLEN-1:0] o_s,
  output logic [XLEN-1:0] o_e,
  output logic [XLEN-1:0] o_w,
  output logic            o_n_valid,
  output logic            o_s_valid,
  output logic            o_e_valid,
  output logic            o_w_valid,
  input  logic            i_n_ready,
  input  logic            i_s_ready,
  input  logic            i_e_ready,
  input  logic            i_w_ready
);

  logic [XLEN-1:0] head [4];
  logic [3:0]      valid;
  logic [3:0]      ready;
  logic [3:0]      accept;
  logic [3:0]      push;
  logic [3:0]      stall_term;
  logic            nbr;
  dir_e            dir;

  assign nbr   = wb_valid && is_nbr_addr(wb_rd);
  assign dir   = addr_to_dir(wb_rd);
  assign rf_we = wb_valid && !is_nbr_addr(wb_rd) && (wb_rd != 5'd0);

  // Queue index equals the dir_e encoding.
  assign ready = {i_e_ready, i_w_ready, i_s_ready, i_n_ready};

  always_comb begin
    push       = '0;
    stall_term = '0;
    for (int i = 0; i < 4; i++) begin
      push[i]       = nbr && (dir == 2'(i)) && accept[i];
      stall_term[i] = nbr && (dir == 2'(i)) && !accept[i];
    end
  end

  assign wb_stall = |stall_term;

  for (genvar g = 0; g < 4; g++) begin : g_q
    nbr_fifo #(
      .DEPTH(DEPTH),
      .XLEN (XLEN)
    ) u_q (
      .clk            (clk),
      .rst_n          (rst_n),
      .push           (push[g]),
      .push_data      (wb_data),
      .full_or_popping(accept[g]),
      .pop            (ready[g]),
      .head           (head[g]),
      .valid          (valid[g])
    );
  end

  assign o_n       = head[DIR_N];
  assign o_s       = head[DIR_S];
  assign o_w       = head[DIR_W];
  assign o_e       = head[DIR_E];
  assign o_n_valid = valid[DIR_N];
  assign o_s_valid = valid[DIR_S];
  assign o_w_valid = valid[DIR_W];
  assign o_e_valid = valid[DIR_E];

endmodule

// File: tb/tb_write_reg.sv
// Directed bench for write_reg: reset, local/neighbour steering, backpressure, concurrency, async reset.
module tb_write_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        rf_we, wb_stall;
  logic [31:0] o_n, o_s, o_e, o_w;
  logic        o_n_valid, o_s_valid, o_e_valid, o_w_valid;
  logic        i_n_ready, i_s_ready, i_e_ready, i_w_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  write_reg #(.DEPTH(2), .XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .rf_we(rf_we), .wb_stall(wb_stall),
    .o_n(o_n), .o_s(o_s), .o_e(o_e), .o_w(o_w),
    .o_n_valid(o_n_valid), .o_s_valid(o_s_valid), .o_e_valid(o_e_valid), .o_w_valid(o_w_valid),
    .i_n_ready(i_n_ready), .i_s_ready(i_s_ready), .i_e_ready(i_e_ready), .i_w_ready(i_w_ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wb_valid = 1'b1; wb_rd = 5'd31; wb_data = 32'hDEADBEEF;
    repeat (2) tick();
    checks++;
    if ({rf_we, wb_stall} !== 2'b00) begin
      errors++; $display("FAIL reset_ctl: got rf_we/stall=%b required 00", {rf_we, wb_stall});
    end
    checks++;
    if ({o_n_valid, o_s_valid, o_e_valid, o_w_valid} !== 4'b0000) begin
      errors++; $display("FAIL reset_valid: got %b required 0000", {o_n_valid, o_s_valid, o_e_valid, o_w_valid});
    end
    checks++;
    if ({o_n, o_s, o_e, o_w} !== 128'd0) begin
      errors++; $display("FAIL reset_data: got %h required 0", {o_n, o_s, o_e, o_w});
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if ({rf_we, wb_stall} !== 2'b00) begin
      errors++; $display("FAIL n_push_ctl: got rf_we/stall=%b required 00", {rf_we, wb_stall});
    end
    tick();
    wb_valid = 1'b0;
    #1;
    checks++;
    if (o_n_valid !== 1'b1 || o_n !== 32'hDEADBEEF) begin
      errors++; $display("FAIL n_first_data: got v=%b d=%h required v=1 d=deadbeef", o_n_valid, o_n);
    end
    i_n_ready = 1'b1;
    tick();
    i_n_ready = 1'b0;
    checks++;
    if (o_n_valid !== 1'b0) begin
      errors++; $display("FAIL n_pop_empty: got v=%b required 0", o_n_valid);
    end
  endtask

  task automatic test_local();
    wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'h12;
    #1;
    checks++;
    if ({rf_we, wb_stall} !== 2'b10) begin
      errors++; $display("FAIL local_rd5: got rf_we/stall=%b required 10", {rf_we, wb_stall});
    end
    tick();
    wb_rd = 5'd0;
    #1;
    checks++;
    if ({o_n_valid, o_s_valid, o_e_valid, o_w_valid} !== 4'b0000) begin
      errors++; $display("FAIL local_no_queue: got %b required 0000", {o_n_valid, o_s_valid, o_e_valid, o_w_valid});
    end
    checks++;
    if ({rf_we, wb_stall} !== 2'b00) begin
      errors++; $display("FAIL local_rd0: got rf_we/stall=%b required 00", {rf_we, wb_stall});
    end
    tick();
    wb_valid = 1'b0;
    #1;
    checks++;
    if ({o_n_valid, o_s_valid, o_e_valid, o_w_valid} !== 4'b0000) begin
      errors++; $display("FAIL rd0_no_queue: got %b required 0000", {o_n_valid, o_s_valid, o_e_valid, o_w_valid});
    end
  endtask

  task automatic test_backpressure();
    i_e_ready = 1'b0; wb_valid = 1'b1; wb_rd = 5'd28;
    for (int k = 1; k <= 2; k++) begin
      wb_data = k;
      #1;
      checks++;
      if (wb_stall !== 1'b0) begin
        errors++; $display("FAIL e_push%0d_stall: got %b required 0", k, wb_stall);
      end
      tick();
    end
    wb_data = 32'd3;
    #1;
    checks++;
    if ({wb_stall, rf_we} !== 2'b10) begin
      errors++; $display("FAIL e_full_stall: got stall/rf_we=%b required 10", {wb_stall, rf_we});
    end
    tick();
    checks++;
    if (wb_stall !== 1'b1 || o_e !== 32'd1 || o_e_valid !== 1'b1) begin
      errors++; $display("FAIL e_held: got stall=%b v=%b d=%0d required 1 1 1", wb_stall, o_e_valid, o_e);
    end
    i_e_ready = 1'b1;
    #1;
    checks++;
    if (wb_stall !== 1'b0) begin
      errors++; $display("FAIL e_pop_accept: got stall=%b required 0", wb_stall);
    end
    tick();
    wb_valid = 1'b0;
    #1;
    checks++;
    if (o_e_valid !== 1'b1 || o_e !== 32'd2) begin
      errors++; $display("FAIL e_order2: got v=%b d=%0d required v=1 d=2", o_e_valid, o_e);
    end
    tick();
    checks++;
    if (o_e_valid !== 1'b1 || o_e !== 32'd3) begin
      errors++; $display("FAIL e_order3: got v=%b d=%0d required v=1 d=3", o_e_valid, o_e);
    end
    tick();
    checks++;
    if (o_e_valid !== 1'b0) begin
      errors++; $display("FAIL e_drained: got v=%b required 0", o_e_valid);
    end
    i_e_ready = 1'b0;
  endtask

  task automatic test_concurrent();
    logic [31:0] nq[$];
    logic        exp_stall;
    logic        push_n;
    i_n_ready = 1'b1; i_w_ready = 1'b0;
    for (int i = 0; i < 18; i++) begin
      exp_stall = 1'b0; push_n = 1'b0; wb_valid = 1'b1;
      if (i == 1 || i == 3) begin
        wb_rd = 5'd29; wb_data = 32'hA00 + i;
      end else if (i == 5 || i == 9) begin
        wb_rd = 5'd29; wb_data = 32'hBAD; exp_stall = 1'b1;
      end else begin
        wb_rd = 5'd31; wb_data = 32'h100 + i; push_n = 1'b1;
      end
      #1;
      checks++;
      if (wb_stall !== exp_stall) begin
        errors++; $display("FAIL conc_stall[%0d]: got %b required %b", i, wb_stall, exp_stall);
      end
      checks++;
      if (o_n_valid !== (nq.size() != 0)) begin
        errors++; $display("FAIL conc_n_valid[%0d]: got %b required %b", i, o_n_valid, nq.size() != 0);
      end else if (nq.size() != 0) begin
        checks++;
        if (o_n !== nq[0]) begin
          errors++; $display("FAIL conc_n_data[%0d]: got %h required %h", i, o_n, nq[0]);
        end
      end
      tick();
      if (nq.size() != 0) void'(nq.pop_front());
      if (push_n) nq.push_back(wb_data);
    end
    wb_valid = 1'b0;
    #1;
    checks++;
    if (o_n_valid !== 1'b1 || o_n !== 32'h111) begin
      errors++; $display("FAIL conc_n_last: got v=%b d=%h required v=1 d=111", o_n_valid, o_n);
    end
    tick();
    checks++;
    if (o_n_valid !== 1'b0) begin
      errors++; $display("FAIL conc_n_drained: got v=%b required 0", o_n_valid);
    end
    checks++;
    if (o_w_valid !== 1'b1 || o_w !== 32'hA01) begin
      errors++; $display("FAIL conc_w_head1: got v=%b d=%h required v=1 d=a01", o_w_valid, o_w);
    end
    i_w_ready = 1'b1;
    tick();
    checks++;
    if (o_w_valid !== 1'b1 || o_w !== 32'hA03) begin
      errors++; $display("FAIL conc_w_head2: got v=%b d=%h required v=1 d=a03", o_w_valid, o_w);
    end
    tick();
    checks++;
    if (o_w_valid !== 1'b0) begin
      errors++; $display("FAIL conc_w_drained: got v=%b required 0", o_w_valid);
    end
    i_w_ready = 1'b0; i_n_ready = 1'b0;
  endtask

  task automatic test_push_pop();
    i_n_ready = 1'b0; wb_valid = 1'b1; wb_rd = 5'd31; wb_data = 32'h55;
    tick();
    wb_data = 32'h66; i_n_ready = 1'b1;
    #1;
    checks++;
    if (wb_stall !== 1'b0 || o_n !== 32'h55) begin
      errors++; $display("FAIL pp_before: got stall=%b d=%h required 0 55", wb_stall, o_n);
    end
    tick();
    wb_valid = 1'b0;
    #1;
    checks++;
    if (o_n_valid !== 1'b1 || o_n !== 32'h66) begin
      errors++; $display("FAIL pp_new_head: got v=%b d=%h required v=1 d=66", o_n_valid, o_n);
    end
    tick();
    checks++;
    if (o_n_valid !== 1'b0) begin
      errors++; $display("FAIL pp_count1: got v=%b required 0", o_n_valid);
    end
    i_n_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    i_s_ready = 1'b0; wb_valid = 1'b1; wb_rd = 5'd30;
    wb_data = 32'h1;
    tick();
    wb_data = 32'h2;
    tick();
    wb_valid = 1'b0;
    #1;
    checks++;
    if (o_s_valid !== 1'b1 || o_s !== 32'h1) begin
      errors++; $display("FAIL s_loaded: got v=%b d=%h required v=1 d=1", o_s_valid, o_s);
    end
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (o_s_valid !== 1'b0 || o_s !== 32'h0) begin
      errors++; $display("FAIL s_async_rst: got v=%b d=%h required v=0 d=0", o_s_valid, o_s);
    end
    @(negedge clk);
    rst_n = 1'b1; i_s_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (o_s_valid !== 1'b0) begin
        errors++; $display("FAIL s_after_rst[%0d]: got v=%b required 0", k, o_s_valid);
      end
    end
    i_s_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; wb_valid = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
    i_n_ready = 1'b0; i_s_ready = 1'b0; i_e_ready = 1'b0; i_w_ready = 1'b0;
    test_reset();
    test_local();
    test_backpressure();
    test_concurrent();
    test_push_pop();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
